// File: rtl/axi_cnt_pkg.sv
// axi_cnt_pkg: shared states, config word indices and control/status bit positions
package axi_cnt_pkg;
    typedef enum logic [2:0] {IDLE, SEND, RESP, GAP, DONE} state_e;
    localparam int CFG_CTRL   = 0;
    localparam int CFG_BASE   = 1;
    localparam int CFG_START  = 2;
    localparam int CFG_COUNT  = 3;
    localparam int CFG_STEP   = 4;
    localparam int CFG_GAP    = 5;
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
endpackage

// File: rtl/axi_cnt_master_if.sv
// axi_cnt_master_if: AXI-Lite write-only channel bundle (AW, W, B)
interface axi_cnt_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr_o;
    logic                  awvalid_o;
    logic                  awready_i;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [3:0]            wstrb_o;
    logic                  wvalid_o;
    logic                  wready_i;
    logic [1:0]            bresp_i;
    logic                  bvalid_i;
    logic                  bready_o;
    modport master (
        output awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        input  awready_i, wready_i, bresp_i, bvalid_i
    );
    modport slave (
        input  awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        output awready_i, wready_i, bresp_i, bvalid_i
    );
endinterface

// File: rtl/axi_lite_wr_beat.sv
// axi_lite_wr_beat: one AXI-Lite write beat with registered valids/ready; go loads the payload
module axi_lite_wr_beat #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  aw_w_done_o,
    output logic                  b_done_o,
    output logic [1:0]            bresp_o,
    axi_cnt_master_if.master      bus
);
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;

    always_comb begin
        awvalid_d   = go | (awvalid_q & ~bus.awready_i);
        wvalid_d    = go | (wvalid_q & ~bus.wready_i);
        // last outstanding AW/W handshake completes this cycle
        aw_w_done_o = (awvalid_q | wvalid_q) & ~(awvalid_q & ~bus.awready_i) & ~(wvalid_q & ~bus.wready_i);
        b_done_o    = bready_q & bus.bvalid_i;
        bready_d    = aw_w_done_o | (bready_q & ~bus.bvalid_i);
        awaddr_d    = go ? addr_i : awaddr_q;
        wdata_d     = go ? data_i : wdata_q;
        wstrb_d     = go ? 4'hF : wstrb_q;
        bresp_o     = bus.bresp_i;
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign bus.awvalid_o = awvalid_q;
    assign bus.wvalid_o  = wvalid_q;
    assign bus.bready_o  = bready_q;
    assign bus.awaddr_o  = awaddr_q;
    assign bus.wdata_o   = wdata_q;
    assign bus.wstrb_o   = wstrb_q;
endmodule

// File: rtl/axi_cnt_master.sv
// axi_cnt_master: writes N counting words over AXI-Lite; AXI_CNT_STOP_ON_ERR_EN ends a run on the first error response
module axi_cnt_master
    import axi_cnt_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BRAM_QUANTITY = 6
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] cfg_i [BRAM_QUANTITY],
    output logic [2:0]            status_o,
    axi_cnt_master_if.master      bus
);
`ifdef AXI_CNT_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif
    state_e                state_q, state_d;
    logic                  start_hist_q;
    logic [DATA_WIDTH-1:0] base_q, base_d, count_q, count_d, step_q, step_d, gap_q, gap_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d, data_q, data_d, gap_cnt_q, gap_cnt_d;
    logic                  err_q, err_d, abort_q, abort_d;
    logic                  start_edge, abort_now, go, aw_w_done, b_done, unused_cfg;
    logic [1:0]            bresp;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign unused_cfg = ^cfg_i[CFG_CTRL][DATA_WIDTH-1:2];

    always_comb begin
        start_edge = cfg_i[CFG_CTRL][CTRL_START] & ~start_hist_q;
        abort_now  = cfg_i[CFG_CTRL][CTRL_ABORT];
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        step_d     = step_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        data_d     = data_q;
        gap_cnt_d  = gap_cnt_q;
        err_d      = err_q;
        abort_d    = abort_q;
        case (state_q)
            IDLE, DONE: if (start_edge) begin
                base_d  = cfg_i[CFG_BASE];
                count_d = cfg_i[CFG_COUNT];
                step_d  = cfg_i[CFG_STEP];
                gap_d   = cfg_i[CFG_GAP];
                idx_d   = '0;
                data_d  = cfg_i[CFG_START];
                err_d   = 1'b0;
                abort_d = 1'b0;
                state_d = (cfg_i[CFG_COUNT] == '0) ? DONE : SEND;
            end
            SEND: begin
                abort_d = abort_q | abort_now;
                state_d = aw_w_done ? RESP : SEND;
            end
            RESP: begin
                abort_d = abort_q | abort_now;
                if (b_done) begin
                    idx_d     = idx_q + DATA_WIDTH'(1);
                    data_d    = data_q + step_q;
                    err_d     = err_q | (bresp != 2'b00);
                    gap_cnt_d = gap_q;
                    state_d   = (idx_d == count_q || abort_d || (STOP_ON_ERR && bresp != 2'b00)) ? DONE :
                                (gap_q != '0) ? GAP : SEND;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - DATA_WIDTH'(1);
                state_d   = abort_now ? DONE : (gap_cnt_q == DATA_WIDTH'(1)) ? SEND : GAP;
            end
            default: state_d = IDLE;
        endcase
        // payload is loaded into the beat on every entry to SEND
        go        = (state_d == SEND) && (state_q != SEND);
        beat_addr = ADDR_WIDTH'(base_d) + (ADDR_WIDTH'(idx_d) << 2);
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q      <= IDLE;
            start_hist_q <= 1'b0;
            base_q       <= '0;
            count_q      <= '0;
            step_q       <= '0;
            gap_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            gap_cnt_q    <= '0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_hist_q <= cfg_i[CFG_CTRL][CTRL_START];
            base_q       <= base_d;
            count_q      <= count_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            gap_cnt_q    <= gap_cnt_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
        end
    end

    assign status_o[ST_BUSY] = state_q inside {SEND, RESP, GAP};
    assign status_o[ST_DONE] = state_q == DONE;
    assign status_o[ST_ERR]  = err_q;

    axi_lite_wr_beat #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_beat (
        .clk         (clk),
        .areset      (areset),
        .go          (go),
        .addr_i      (beat_addr),
        .data_i      (data_d),
        .aw_w_done_o (aw_w_done),
        .b_done_o    (b_done),
        .bresp_o     (bresp),
        .bus         (bus)
    );
endmodule

// File: tb/tb_axi_cnt_master.sv
// tb_axi_cnt_master: directed and random runs against an AXI-Lite slave model and an arithmetic write-list model
module tb_axi_cnt_master;
    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [31:0] cfg [6];
    logic [2:0]  status;
    int          n_asrt = 0, n_fail = 0, cyc = 0;

    int          aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0, err_idx = -1, nb = 0;
    bit          rand_rdy = 0, b_hold = 0;
    bit          aw_got, w_got, aw_fire, w_fire, b_fire, aw_pend, w_pend, aw_prev;
    logic [31:0] aw_held, w_held;
    logic [31:0] aw_q[$], w_q[$];
    int          b_cyc[$], rise_cyc[$];

    axi_cnt_master_if bus ();

    axi_cnt_master dut (
        .clk      (clk),
        .areset   (areset),
        .cfg_i    (cfg),
        .status_o (status),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slave: decides ready/bvalid at the negedge for the following posedge
    initial begin
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b0;
        bus.bvalid_i  = 1'b0;
        bus.bresp_i   = 2'b00;
        forever begin
            @(negedge clk);
            if (!areset) begin
                bus.awready_i = 1'b0;
                bus.wready_i  = 1'b0;
                bus.bvalid_i  = 1'b0;
                bus.bresp_i   = 2'b00;
                {aw_got, w_got, aw_fire, w_fire, b_fire, aw_pend, w_pend, aw_prev} = '0;
                aw_wait = 0;
                w_wait  = 0;
            end else begin
                if (aw_fire) aw_got = 1;
                if (w_fire) w_got = 1;
                if (b_fire) begin
                    aw_got = 0;
                    w_got = 0;
                    bus.bvalid_i = 1'b0;
                    bus.bresp_i = 2'b00;
                end
                if (aw_pend) begin
                    chk("aw_valid_held", bus.awvalid_o, 1);
                    chk("aw_addr_held", bus.awaddr_o, aw_held);
                end
                if (w_pend) begin
                    chk("w_valid_held", bus.wvalid_o, 1);
                    chk("w_data_held", bus.wdata_o, w_held);
                end
                if (bus.awvalid_o && !aw_prev) rise_cyc.push_back(cyc);
                aw_prev = bus.awvalid_o;
                bus.awready_i = bus.awvalid_o && !aw_got && (rand_rdy ? ($urandom_range(2, 0) != 0) : (aw_wait >= aw_dly));
                bus.wready_i  = bus.wvalid_o && !w_got && (rand_rdy ? ($urandom_range(2, 0) != 0) : (w_wait >= w_dly));
                aw_fire = bus.awvalid_o && bus.awready_i;
                w_fire  = bus.wvalid_o && bus.wready_i;
                aw_wait = (bus.awvalid_o && !aw_fire) ? aw_wait + 1 : 0;
                w_wait  = (bus.wvalid_o && !w_fire) ? w_wait + 1 : 0;
                aw_pend = bus.awvalid_o && !aw_fire;
                w_pend  = bus.wvalid_o && !w_fire;
                aw_held = bus.awaddr_o;
                w_held  = bus.wdata_o;
                if (aw_fire) aw_q.push_back(bus.awaddr_o);
                if (w_fire) begin
                    w_q.push_back(bus.wdata_o);
                    chk("wstrb", bus.wstrb_o, 4'hF);
                end
                if (bus.bready_o) chk("bready_only_after_aw_w", aw_got && w_got, 1);
                if (aw_got && w_got && !bus.bvalid_i && !b_hold) begin
                    bus.bvalid_i = 1'b1;
                    bus.bresp_i  = (nb == err_idx) ? 2'd2 : 2'd0;
                end
                b_fire = bus.bvalid_i && bus.bready_o;
                if (b_fire) begin
                    nb++;
                    b_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_log();
        aw_q.delete();
        w_q.delete();
        b_cyc.delete();
        rise_cyc.delete();
        nb = 0;
    endtask

    task automatic start_pulse(input logic [31:0] base, st, step, n, gap);
        @(negedge clk);
        cfg[1] = base;
        cfg[2] = st;
        cfg[3] = n;
        cfg[4] = step;
        cfg[5] = gap;
        cfg[0] = 32'h1;
        @(negedge clk);
        cfg[0] = 32'h0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!status[1] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_in_time"}, status[1], 1);
    endtask

    // expected write list: i-th write goes to base+4i carrying st+i*step, all modulo 2^32
    task automatic run(input string tag, input logic [31:0] base, st, step, n, gap,
                       input int eidx, input int adly, input int wdly, input bit rnd);
        int exp_n;
        bit exp_err;
        logic [31:0] ea, ed;
        err_idx = eidx;
        aw_dly = adly;
        w_dly = wdly;
        rand_rdy = rnd;
        clear_log();
        start_pulse(base, st, step, n, gap);
        wait_done(tag);
        exp_n = int'(n);
`ifdef AXI_CNT_STOP_ON_ERR_EN
        if (eidx >= 0 && eidx < exp_n) exp_n = eidx + 1;
`endif
        exp_err = eidx >= 0 && eidx < exp_n;
        chk({tag, "_aw_count"}, aw_q.size(), exp_n);
        chk({tag, "_w_count"}, w_q.size(), exp_n);
        chk({tag, "_b_count"}, nb, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            ea = base + 32'(4 * i);
            ed = st + step * 32'(i);
            if (i < aw_q.size()) chk($sformatf("%s_addr%0d", tag, i), aw_q[i], ea);
            if (i < w_q.size()) chk($sformatf("%s_data%0d", tag, i), w_q[i], ed);
        end
        chk({tag, "_status"}, status, {exp_err, 2'b10});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 6; i++) cfg[i] = '0;
        areset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", bus.awvalid_o, 0);
        chk("rst_wvalid", bus.wvalid_o, 0);
        chk("rst_bready", bus.bready_o, 0);
        chk("rst_awaddr", bus.awaddr_o, 0);
        chk("rst_wdata", bus.wdata_o, 0);
        chk("rst_wstrb", bus.wstrb_o, 0);
        chk("rst_status", status, 0);
        areset = 1'b1;
        @(negedge clk);

        run("basic", 32'h0, 32'd5, 32'd3, 32'd4, 32'd0, -1, 0, 0, 0);
        if (rise_cyc.size() > 1 && b_cyc.size() > 0)
            chk("gap0_throughput", (rise_cyc[1] - b_cyc[0] - 1) <= 1, 1);

        run("slow_ready", 32'h40, 32'h1234, 32'd1, 32'd1, 32'd0, -1, 3, 1, 0);
        chk("slow_ready_single_valid", rise_cyc.size(), 1);

        run("bresp_err", 32'h100, 32'd7, 32'd2, 32'd3, 32'd0, 1, 0, 0, 0);

        clear_log();
        @(negedge clk);
        cfg[3] = 32'd0;
        cfg[0] = 32'h1;
        @(negedge clk);
        chk("n0_status", status, 3'b010);
        cfg[3] = 32'd3;
        repeat (10) @(negedge clk);
        chk("n0_held_status", status, 3'b010);
        chk("n0_no_awvalid", rise_cyc.size(), 0);
        cfg[0] = 32'h0;

        run("wrap_gap", 32'h200, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd2, -1, 0, 0, 0);
        if (rise_cyc.size() > 1 && b_cyc.size() > 0)
            chk("gap2_idle_cycles", rise_cyc[1] - b_cyc[0] - 1, 2);

        err_idx = -1;
        aw_dly = 2;
        w_dly = 0;
        rand_rdy = 0;
        clear_log();
        start_pulse(32'h300, 32'd1, 32'd1, 32'd5, 32'd0);
        for (int k = 0; k < 200 && rise_cyc.size() < 2; k++) @(negedge clk);
        chk("abort_in_send", bus.awvalid_o, 1);
        cfg[0] = 32'h2;
        wait_done("abort");
        cfg[0] = 32'h0;
        chk("abort_writes", aw_q.size(), 2);
        chk("abort_b_count", nb, 2);
        if (aw_q.size() > 1) chk("abort_addr1", aw_q[1], 32'h304);
        chk("abort_status", status, 3'b010);

        clear_log();
        b_hold = 1;
        start_pulse(32'h400, 32'd9, 32'd1, 32'd5, 32'd0);
        for (int k = 0; k < 200 && !bus.bready_o; k++) @(negedge clk);
        chk("resp_before_reset", bus.bready_o, 1);
        chk("resp_busy", status, 3'b001);
        areset = 1'b0;
        @(negedge clk);
        chk("midrst_awvalid", bus.awvalid_o, 0);
        chk("midrst_wvalid", bus.wvalid_o, 0);
        chk("midrst_bready", bus.bready_o, 0);
        chk("midrst_awaddr", bus.awaddr_o, 0);
        chk("midrst_wdata", bus.wdata_o, 0);
        chk("midrst_wstrb", bus.wstrb_o, 0);
        chk("midrst_status", status, 0);
        b_hold = 0;
        areset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_status", status, 0);
        chk("post_rst_no_new_write", rise_cyc.size(), 1);

        for (int r = 0; r < 5; r++) begin
            logic [31:0] n;
            n = 32'($urandom_range(6, 1));
            run($sformatf("rand%0d", r), $urandom, $urandom, $urandom, n, 32'($urandom_range(3, 0)),
                int'($urandom_range(int'(n), 0)), 0, 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
